// File: rtl/sap1_control_sequencer.sv
// Purpose: SAP-1 control unit: T1..T6 ring sequencer plus opcode decode into datapath strobes.
// Latency: controls are Moore outputs of the current state (plus OPCODE in T4..T6); every instruction takes 6 cycles, HLT reaches HALT after 4.
// Backpressure: none; PROG_RUN=1 preempts any T-state or HALT on the next edge and aborts the instruction.
module sap1_control_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       PROG_RUN,
  input  logic [3:0] OPCODE,
  output logic       CLR,
  output logic       CP,
  output logic       EP,
  output logic       LM,
  output logic       CE,
  output logic       LI,
  output logic       EI,
  output logic       LA,
  output logic       EA,
  output logic       SU,
  output logic       EU,
  output logic       LB,
  output logic       LO,
  output logic       HALTED,
  output logic [5:0] T_STATE,
  output logic [7:0] INSTR_COUNT
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] PROGRAM = 4'd1;
  localparam logic [3:0] T1      = 4'd2;
  localparam logic [3:0] T2      = 4'd3;
  localparam logic [3:0] T3      = 4'd4;
  localparam logic [3:0] T4      = 4'd5;
  localparam logic [3:0] T5      = 4'd6;
  localparam logic [3:0] T6      = 4'd7;
  localparam logic [3:0] HALT    = 4'd8;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       instr_done;

  // Next-state selection; program mode overrides everything except IDLE/PROGRAM handling.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = PROG_RUN ? PROGRAM : T1;
      PROGRAM: state_nxt = PROG_RUN ? PROGRAM : IDLE;
      T1:      state_nxt = T2;
      T2:      state_nxt = T3;
      T3:      state_nxt = T4;
      T4:      state_nxt = (OPCODE == OP_HLT) ? HALT : T5;
      T5:      state_nxt = T6;
      T6:      state_nxt = T1;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
    if (PROG_RUN && (state != IDLE) && (state != PROGRAM)) begin
      state_nxt = PROGRAM;
    end
  end

  // An instruction retires at the end of T6, or at T4 for HLT, unless aborted by PROG_RUN.
  assign instr_done = !PROG_RUN &&
                      ((state == T6) || ((state == T4) && (OPCODE == OP_HLT)));

  // State register and retired-instruction counter (wraps naturally at 8 bits).
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      INSTR_COUNT <= 8'd0;
    end else begin
      state <= state_nxt;
      if (instr_done) begin
        INSTR_COUNT <= INSTR_COUNT + 8'd1;
      end
    end
  end

  // Control word decode: fixed fetch in T1..T3, opcode-dependent execute in T4..T6.
  always_comb begin
    CLR     = 1'b0;
    CP      = 1'b0;
    EP      = 1'b0;
    LM      = 1'b0;
    CE      = 1'b0;
    LI      = 1'b0;
    EI      = 1'b0;
    LA      = 1'b0;
    EA      = 1'b0;
    SU      = 1'b0;
    EU      = 1'b0;
    LB      = 1'b0;
    LO      = 1'b0;
    HALTED  = 1'b0;
    T_STATE = 6'b000000;
    case (state)
      IDLE: CLR = 1'b1;
      T1: begin
        T_STATE = 6'b000001;
        EP      = 1'b1;
        LM      = 1'b1;
      end
      T2: begin
        T_STATE = 6'b000010;
        CP      = 1'b1;
      end
      T3: begin
        T_STATE = 6'b000100;
        CE      = 1'b1;
        LI      = 1'b1;
      end
      T4: begin
        T_STATE = 6'b001000;
        if ((OPCODE == OP_LDA) || (OPCODE == OP_ADD) || (OPCODE == OP_SUB)) begin
          EI = 1'b1;
          LM = 1'b1;
        end else if (OPCODE == OP_OUT) begin
          EA = 1'b1;
          LO = 1'b1;
        end
      end
      T5: begin
        T_STATE = 6'b010000;
        if (OPCODE == OP_LDA) begin
          CE = 1'b1;
          LA = 1'b1;
        end else if ((OPCODE == OP_ADD) || (OPCODE == OP_SUB)) begin
          CE = 1'b1;
          LB = 1'b1;
          // Select subtract one cycle early so the ALU result is settled for T6.
          SU = (OPCODE == OP_SUB);
        end
      end
      T6: begin
        T_STATE = 6'b100000;
        if ((OPCODE == OP_ADD) || (OPCODE == OP_SUB)) begin
          EU = 1'b1;
          LA = 1'b1;
          SU = (OPCODE == OP_SUB);
        end
      end
      HALT: HALTED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Purpose: directed bench for sap1_control_sequencer, including a small SAP-1 datapath model.
// Latency: outputs sampled on the falling clock edge, half a cycle after each state change.
// Backpressure: not applicable; PROG_RUN abort paths are exercised directly.
module tb_sap1_control_sequencer;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       PROG_RUN = 1'b0;
  logic [3:0] OPCODE;
  logic CLR, CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, HALTED;
  logic [5:0] T_STATE;
  logic [7:0] INSTR_COUNT;

  int checks = 0;
  int errors = 0;

  // Control-word bit masks, ordered {CLR,CP,EP,LM,CE,LI,EI,LA,EA,SU,EU,LB,LO}.
  localparam logic [12:0] M_CLR = 13'h1000;
  localparam logic [12:0] M_CP  = 13'h0800;
  localparam logic [12:0] M_EP  = 13'h0400;
  localparam logic [12:0] M_LM  = 13'h0200;
  localparam logic [12:0] M_CE  = 13'h0100;
  localparam logic [12:0] M_LI  = 13'h0080;
  localparam logic [12:0] M_EI  = 13'h0040;
  localparam logic [12:0] M_LA  = 13'h0020;
  localparam logic [12:0] M_EA  = 13'h0010;
  localparam logic [12:0] M_SU  = 13'h0008;
  localparam logic [12:0] M_EU  = 13'h0004;
  localparam logic [12:0] M_LB  = 13'h0002;
  localparam logic [12:0] M_LO  = 13'h0001;

  logic [12:0] ctl;
  assign ctl = {CLR, CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO};

  // Datapath model: OPCODE comes from its IR when use_dp is set, else from forced_op.
  logic       use_dp = 1'b0;
  logic [3:0] forced_op = 4'h0;
  logic [7:0] ram [16];
  logic [3:0] pc, mar;
  logic [7:0] ir, a_reg, b_reg, out_reg, bus;

  assign OPCODE = use_dp ? ir[7:4] : forced_op;

  always_comb begin
    bus = 8'h00;
    if (EP)      bus = {4'h0, pc};
    else if (CE) bus = ram[mar];
    else if (EI) bus = {4'h0, ir[3:0]};
    else if (EA) bus = a_reg;
    else if (EU) bus = SU ? (a_reg - b_reg) : (a_reg + b_reg);
  end

  always @(posedge CLOCK) begin
    if (CLR) begin
      pc <= 4'h0; ir <= 8'h00; a_reg <= 8'h00; b_reg <= 8'h00; out_reg <= 8'h00;
    end else begin
      if (CP) pc <= pc + 4'h1;
      if (LM) mar <= bus[3:0];
      if (LI) ir <= bus;
      if (LA) a_reg <= bus;
      if (LB) b_reg <= bus;
      if (LO) out_reg <= bus;
    end
  end

  sap1_control_sequencer dut (
    .CLOCK(CLOCK), .RESET(RESET), .PROG_RUN(PROG_RUN), .OPCODE(OPCODE),
    .CLR(CLR), .CP(CP), .EP(EP), .LM(LM), .CE(CE), .LI(LI), .EI(EI),
    .LA(LA), .EA(EA), .SU(SU), .EU(EU), .LB(LB), .LO(LO),
    .HALTED(HALTED), .T_STATE(T_STATE), .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  // At most one bus driver at any sampled point.
  always @(negedge CLOCK) begin
    checks++;
    assert ($countones({EP, CE, EI, EA, EU}) <= 1) else begin
      errors++;
      $display("FAIL bus_conflict: drivers EP,CE,EI,EA,EU = %b, required at most one", {EP, CE, EI, EA, EU});
    end
  end

  // Reset pulse released before a rising edge; returns at the falling edge in T1 (or PROGRAM).
  task automatic do_reset(input logic pr);
    @(negedge CLOCK);
    RESET = 1'b0;
    PROG_RUN = pr;
    #1;
    RESET = 1'b1;
    @(negedge CLOCK);
  endtask

  task automatic test_reset();
    @(negedge CLOCK);
    RESET = 1'b0; PROG_RUN = 1'b0; forced_op = 4'h0;
    #1;
    checks++;
    if (ctl !== M_CLR || T_STATE !== 6'd0 || HALTED !== 1'b0 || INSTR_COUNT !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: ctl=%h T=%b H=%b cnt=%0d, required ctl=%h T=0 H=0 cnt=0", ctl, T_STATE, HALTED, INSTR_COUNT, M_CLR);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (ctl !== M_CLR || T_STATE !== 6'd0) begin
      errors++;
      $display("FAIL idle_after_release: ctl=%h T=%b, required ctl=%h T=0", ctl, T_STATE, M_CLR);
    end
    @(negedge CLOCK);
    checks++;
    if (ctl !== (M_EP | M_LM) || T_STATE !== 6'b000001 || INSTR_COUNT !== 8'd0) begin
      errors++;
      $display("FAIL first_t1: ctl=%h T=%b cnt=%0d, required ctl=%h T=000001 cnt=0", ctl, T_STATE, INSTR_COUNT, M_EP | M_LM);
    end
  endtask

  task automatic test_program_run();
    logic [7:0] img [16];
    img = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hEF, 8'hFF, 8'h00, 8'h00,
            8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) begin
      ram[i] = img[i];
      @(negedge CLOCK);
      checks++;
      if (ctl !== 13'd0 || T_STATE !== 6'd0 || HALTED !== 1'b0) begin
        errors++;
        $display("FAIL program_quiet[%0d]: ctl=%h T=%b H=%b, required all 0", i, ctl, T_STATE, HALTED);
      end
    end
    use_dp = 1'b1;
    PROG_RUN = 1'b0;
    @(negedge CLOCK);
    checks++;
    if (ctl !== M_CLR || T_STATE !== 6'd0) begin
      errors++;
      $display("FAIL program_exit_clr: ctl=%h T=%b, required ctl=%h T=0", ctl, T_STATE, M_CLR);
    end
    @(negedge CLOCK);
    checks++;
    if (T_STATE !== 6'b000001) begin
      errors++;
      $display("FAIL program_exit_t1: T=%b, required 000001", T_STATE);
    end
    for (int i = 0; i < 100 && !HALTED; i++) @(negedge CLOCK);
    checks++;
    if (HALTED !== 1'b1 || out_reg !== 8'h02 || INSTR_COUNT !== 8'd6) begin
      errors++;
      $display("FAIL program_result: H=%b out=%h cnt=%0d, required H=1 out=02 cnt=6", HALTED, out_reg, INSTR_COUNT);
    end
    use_dp = 1'b0;
  endtask

  task automatic test_decode();
    logic [3:0]  ops [5];
    logic [12:0] exe [5][3];
    logic [12:0] fetch [3];
    logic [12:0] want;
    ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h7};
    fetch = '{M_EP | M_LM, M_CP, M_CE | M_LI};
    exe[0] = '{M_EI | M_LM, M_CE | M_LA, 13'd0};
    exe[1] = '{M_EI | M_LM, M_CE | M_LB, M_EU | M_LA};
    exe[2] = '{M_EI | M_LM, M_CE | M_LB | M_SU, M_SU | M_EU | M_LA};
    exe[3] = '{M_EA | M_LO, 13'd0, 13'd0};
    exe[4] = '{13'd0, 13'd0, 13'd0};
    forced_op = ops[0];
    do_reset(1'b0);
    for (int n = 0; n < 5; n++) begin
      forced_op = ops[n];
      for (int k = 0; k < 6; k++) begin
        #1;
        want = (k < 3) ? fetch[k] : exe[n][k-3];
        checks++;
        if (ctl !== want || T_STATE !== (6'b1 << k)) begin
          errors++;
          $display("FAIL decode op=%h T%0d: ctl=%h T=%b, required ctl=%h T=%b", ops[n], k + 1, ctl, T_STATE, want, 6'b1 << k);
        end
        @(negedge CLOCK);
      end
      checks++;
      if (INSTR_COUNT !== 8'(n + 1)) begin
        errors++;
        $display("FAIL decode_count op=%h: cnt=%0d, required %0d", ops[n], INSTR_COUNT, n + 1);
      end
    end
  endtask

  task automatic test_halt();
    forced_op = 4'hF;
    do_reset(1'b0);
    repeat (3) @(negedge CLOCK);
    checks++;
    if (T_STATE !== 6'b001000 || ctl !== 13'd0) begin
      errors++;
      $display("FAIL halt_t4: T=%b ctl=%h, required T=001000 ctl=0", T_STATE, ctl);
    end
    @(negedge CLOCK);
    checks++;
    if (HALTED !== 1'b1 || T_STATE !== 6'd0 || ctl !== 13'd0 || INSTR_COUNT !== 8'd1) begin
      errors++;
      $display("FAIL halt_enter: H=%b T=%b ctl=%h cnt=%0d, required H=1 T=0 ctl=0 cnt=1", HALTED, T_STATE, ctl, INSTR_COUNT);
    end
    repeat (50) @(negedge CLOCK);
    checks++;
    if (HALTED !== 1'b1 || T_STATE !== 6'd0 || INSTR_COUNT !== 8'd1) begin
      errors++;
      $display("FAIL halt_stay: H=%b T=%b cnt=%0d, required H=1 T=0 cnt=1", HALTED, T_STATE, INSTR_COUNT);
    end
    PROG_RUN = 1'b1;
    @(negedge CLOCK);
    checks++;
    if (HALTED !== 1'b0 || ctl !== 13'd0 || T_STATE !== 6'd0) begin
      errors++;
      $display("FAIL halt_to_program: H=%b ctl=%h T=%b, required all 0", HALTED, ctl, T_STATE);
    end
    PROG_RUN = 1'b0;
    @(negedge CLOCK);
    checks++;
    if (ctl !== M_CLR) begin
      errors++;
      $display("FAIL halt_idle_clr: ctl=%h, required %h", ctl, M_CLR);
    end
    @(negedge CLOCK);
    checks++;
    if (T_STATE !== 6'b000001 || ctl !== (M_EP | M_LM)) begin
      errors++;
      $display("FAIL halt_restart_t1: T=%b ctl=%h, required T=000001 ctl=%h", T_STATE, ctl, M_EP | M_LM);
    end
  endtask

  task automatic test_abort();
    forced_op = 4'h1;
    do_reset(1'b0);
    repeat (6) @(negedge CLOCK);
    repeat (4) @(negedge CLOCK);
    checks++;
    if (T_STATE !== 6'b010000 || INSTR_COUNT !== 8'd1) begin
      errors++;
      $display("FAIL abort_setup: T=%b cnt=%0d, required T=010000 cnt=1", T_STATE, INSTR_COUNT);
    end
    PROG_RUN = 1'b1;
    @(negedge CLOCK);
    checks++;
    if (T_STATE !== 6'd0 || ctl !== 13'd0 || INSTR_COUNT !== 8'd1) begin
      errors++;
      $display("FAIL abort_program: T=%b ctl=%h cnt=%0d, required T=0 ctl=0 cnt=1", T_STATE, ctl, INSTR_COUNT);
    end
    PROG_RUN = 1'b0;
    repeat (2) @(negedge CLOCK);
    checks++;
    if (T_STATE !== 6'b000001 || INSTR_COUNT !== 8'd1) begin
      errors++;
      $display("FAIL abort_resume: T=%b cnt=%0d, required T=000001 cnt=1", T_STATE, INSTR_COUNT);
    end
  endtask

  task automatic test_async_reset();
    forced_op = 4'h0;
    do_reset(1'b0);
    repeat (8) @(negedge CLOCK);
    checks++;
    if (T_STATE !== 6'b000100 || INSTR_COUNT !== 8'd1) begin
      errors++;
      $display("FAIL async_setup: T=%b cnt=%0d, required T=000100 cnt=1", T_STATE, INSTR_COUNT);
    end
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if (ctl !== M_CLR || T_STATE !== 6'd0 || HALTED !== 1'b0 || INSTR_COUNT !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: ctl=%h T=%b H=%b cnt=%0d, required ctl=%h T=0 H=0 cnt=0", ctl, T_STATE, HALTED, INSTR_COUNT, M_CLR);
    end
    RESET = 1'b1;
  endtask

  task automatic test_wrap();
    forced_op = 4'h7;
    do_reset(1'b0);
    repeat (255 * 6) @(negedge CLOCK);
    checks++;
    if (INSTR_COUNT !== 8'd255 || T_STATE !== 6'b000001) begin
      errors++;
      $display("FAIL wrap_255: cnt=%0d T=%b, required cnt=255 T=000001", INSTR_COUNT, T_STATE);
    end
    repeat (6) @(negedge CLOCK);
    checks++;
    if (INSTR_COUNT !== 8'd0 || T_STATE !== 6'b000001) begin
      errors++;
      $display("FAIL wrap_0: cnt=%0d T=%b, required cnt=0 T=000001", INSTR_COUNT, T_STATE);
    end
  endtask

  initial begin
    test_reset();
    test_program_run();
    test_decode();
    test_halt();
    test_abort();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
